// File: rtl/reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reset_pkg
//  Brief    : Shared types and cause-register bit positions for the f8 reset
//             sequencer.
//  Revision : 1.0
// ============================================================================
package reset_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        STAGGER = 2'd2
    } state_e;

    localparam int CAUSE_POR   = 0;
    localparam int CAUSE_WDT   = 1;
    localparam int CAUSE_TRAP  = 2;
    localparam int CAUSE_EXT   = 3;
    localparam int CAUSE_SW    = 4;
    localparam int CAUSE_SWREQ = 7;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_reset_filter.sv
`default_nettype none
// ============================================================================
//  Module   : ext_reset_filter
//  Brief    : Synchronizes the external reset pin and raises ext_req after
//             EXT_FILTER consecutive low samples.
//  Revision : 1.0
// ============================================================================
module ext_reset_filter #(
    parameter int EXT_FILTER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ext_reset_n,
    output logic ext_req
);

    localparam int                c_filt_w   = $clog2(EXT_FILTER + 1);
    localparam logic [c_filt_w-1:0] c_filt_max = c_filt_w'(EXT_FILTER);
    localparam logic [c_filt_w-1:0] c_filt_one = c_filt_w'(1);

    logic                sync1_q;
    logic                sync2_q;
    logic [c_filt_w-1:0] filt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= '0;
        end else begin
            sync1_q <= ext_reset_n;
            sync2_q <= sync1_q;
            // Saturate so a pin held low keeps the request asserted.
            if (sync2_q) begin
                filt_q <= '0;
            end else if (filt_q != c_filt_max) begin
                filt_q <= filt_q + c_filt_one;
            end
        end
    end

    assign ext_req = (filt_q == c_filt_max);

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Brief    : Merges SoC reset sources, stretches them into staged peripheral
//             and CPU resets, and keeps a sticky W1C cause register.
//  Revision : 1.0
// ============================================================================
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int EXT_FILTER     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wdt_req,
    input  logic       trap,
    input  logic       ext_reset_n,
    input  logic [7:0] cause_in,
    input  logic       cause_write,
    output logic [7:0] cause_out,
    output logic       periph_reset,
    output logic       cpu_reset
);

    localparam int                 c_cnt_w      = $clog2(max2(HOLD_CYCLES, STAGGER_CYCLES));
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stag_last  = c_cnt_w'(STAGGER_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [7:0]         c_cause_mask = 8'h1F;

    state_e             state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic               periph_reset_q;
    logic               cpu_reset_q;
    logic [7:0]         cause_q;
    logic [7:0]         cause_d;

    logic       w_ext_req;
    logic       w_wr_ok;
    logic       w_sw_req;
    logic       w_req;
    logic [7:0] w_set;
    logic [7:0] w_clr;

    ext_reset_filter #(
        .EXT_FILTER (EXT_FILTER)
    ) u_ext_filter (
        .clk         (clk),
        .reset       (reset),
        .ext_reset_n (ext_reset_n),
        .ext_req     (w_ext_req)
    );

    // Software cannot touch the cause register while the CPU is held in reset.
    assign w_wr_ok  = cause_write & ~cpu_reset_q;
    assign w_sw_req = w_wr_ok & cause_in[CAUSE_SWREQ];
    assign w_req    = reset | wdt_req | trap | w_ext_req | w_sw_req;

    always_comb begin
        w_set             = '0;
        w_set[CAUSE_POR]  = reset;
        w_set[CAUSE_WDT]  = wdt_req;
        w_set[CAUSE_TRAP] = trap;
        w_set[CAUSE_EXT]  = w_ext_req;
        w_set[CAUSE_SW]   = w_sw_req;
        w_clr             = w_wr_ok ? cause_in : 8'h00;
        cause_d           = ((cause_q & ~w_clr) | w_set) & c_cause_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q <= 8'h01;
        end else begin
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HOLD;
            cnt_q          <= '0;
            periph_reset_q <= 1'b1;
            cpu_reset_q    <= 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (w_req) begin
                        state_q        <= HOLD;
                        cnt_q          <= '0;
                        periph_reset_q <= 1'b1;
                        cpu_reset_q    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_req) begin
                        cnt_q <= '0;
                    end else if (cnt_q == c_hold_last) begin
                        state_q        <= STAGGER;
                        cnt_q          <= '0;
                        periph_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + c_cnt_one;
                    end
                end
                STAGGER: begin
                    // cpu_reset stays high on re-entry to HOLD, so it never glitches.
                    if (w_req) begin
                        state_q        <= HOLD;
                        cnt_q          <= '0;
                        periph_reset_q <= 1'b1;
                    end else if (cnt_q == c_stag_last) begin
                        state_q     <= RUN;
                        cnt_q       <= '0;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + c_cnt_one;
                    end
                end
                default: begin
                    state_q        <= HOLD;
                    cnt_q          <= '0;
                    periph_reset_q <= 1'b1;
                    cpu_reset_q    <= 1'b1;
                end
            endcase
        end
    end

    assign cause_out    = cause_q;
    assign periph_reset = periph_reset_q;
    assign cpu_reset    = cpu_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Brief    : Directed and random checks of reset_sequencer against an
//             "edges since last request" reference model.
//  Revision : 1.0
// ============================================================================
module tb_reset_sequencer;

    localparam int HOLD = 16;
    localparam int STAG = 4;
    localparam int EXTF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wdt_req = 1'b0;
    logic       trap = 1'b0;
    logic       ext_reset_n = 1'b1;
    logic [7:0] cause_in = 8'h00;
    logic       cause_write = 1'b0;
    logic [7:0] cause_out;
    logic       periph_reset;
    logic       cpu_reset;

    int errors = 0;
    int checks = 0;

    // Reference state: edges since the last request, sticky causes, pin history.
    int          m_n = 0;
    logic [7:0]  m_cause = 8'h01;
    logic [15:0] m_hist = '1;

    reset_sequencer #(
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAG),
        .EXT_FILTER     (EXTF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wdt_req      (wdt_req),
        .trap         (trap),
        .ext_reset_n  (ext_reset_n),
        .cause_in     (cause_in),
        .cause_write  (cause_write),
        .cause_out    (cause_out),
        .periph_reset (periph_reset),
        .cpu_reset    (cpu_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic cpu_prev, wr_ok, sw, ext, req;
        cpu_prev = (m_n < HOLD + STAG);
        wr_ok    = cause_write && !cpu_prev;
        sw       = wr_ok && cause_in[7];
        ext      = 1'b1;
        for (int j = 2; j <= EXTF + 1; j++) begin
            if (m_hist[j]) ext = 1'b0;
        end
        req = reset || wdt_req || trap || ext || sw;
        if (reset) begin
            m_n     = 0;
            m_cause = 8'h01;
            m_hist  = '1;
        end else begin
            if (req)             m_n = 0;
            else if (m_n < 1000) m_n = m_n + 1;
            for (int k = 0; k < 5; k++) begin
                if (wr_ok && cause_in[k]) m_cause[k] = 1'b0;
            end
            if (wdt_req) m_cause[1] = 1'b1;
            if (trap)    m_cause[2] = 1'b1;
            if (ext)     m_cause[3] = 1'b1;
            if (sw)      m_cause[4] = 1'b1;
            m_hist = {m_hist[14:0], ext_reset_n};
        end
    endtask

    // One clock: model and DUT see the same inputs, compare just after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("periph_reset", {7'b0, periph_reset}, {7'b0, (m_n < HOLD)});
        chk("cpu_reset", {7'b0, cpu_reset}, {7'b0, (m_n < HOLD + STAG)});
        chk("cause_out", cause_out, m_cause);
        wdt_req     = 1'b0;
        trap        = 1'b0;
        cause_write = 1'b0;
        cause_in    = 8'h00;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int ext_left;

        // Power-on: reset for 3 cycles then full sequence
        steps(3);
        reset = 1'b0;
        steps(25);
        chk("por_cause", cause_out, 8'h01);
        chk("por_done", {6'b0, periph_reset, cpu_reset}, 8'h00);

        // Watchdog pulse, then clear its cause bit
        wdt_req = 1'b1;
        step();
        steps(22);
        chk("wdt_cause", cause_out, 8'h03);
        cause_write = 1'b1;
        cause_in    = 8'h02;
        step();
        chk("wdt_clear", cause_out, 8'h01);

        // Trap at STAGGER cycle 2 restarts HOLD without dropping cpu_reset
        steps(3);
        wdt_req = 1'b1;
        step();
        steps(HOLD + 1);
        trap = 1'b1;
        step();
        chk("trap_restart", {6'b0, periph_reset, cpu_reset}, 8'h03);
        steps(22);
        chk("trap_cause", cause_out & 8'h04, 8'h04);

        // External pin: short glitch ignored, long hold resets
        ext_reset_n = 1'b0;
        steps(3);
        ext_reset_n = 1'b1;
        steps(10);
        chk("ext_glitch", cause_out & 8'h08, 8'h00);
        ext_reset_n = 1'b0;
        steps(10);
        ext_reset_n = 1'b1;
        steps(30);
        chk("ext_cause", cause_out & 8'h08, 8'h08);

        // Software reset, then a write while cpu_reset is high
        cause_write = 1'b1;
        cause_in    = 8'h80;
        step();
        steps(3);
        cause_write = 1'b1;
        cause_in    = 8'h9F;
        step();
        steps(22);
        chk("sw_cause", cause_out & 8'h90, 8'h10);

        // Set wins over clear on the watchdog bit
        wdt_req     = 1'b1;
        cause_write = 1'b1;
        cause_in    = 8'h02;
        step();
        chk("set_wins", cause_out & 8'h02, 8'h02);
        steps(22);

        // Random traffic
        ext_left = 20;
        for (int i = 0; i < 2000; i++) begin
            reset   = ($urandom_range(0, 399) == 0);
            wdt_req = ($urandom_range(0, 39) == 0);
            trap    = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 14) == 0) begin
                cause_write = 1'b1;
                cause_in    = 8'($urandom) & (($urandom_range(0, 3) == 0) ? 8'hFF : 8'h7F);
            end
            if (ext_left == 0) begin
                ext_reset_n = ~ext_reset_n;
                ext_left    = ext_reset_n ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 9));
            end
            ext_left--;
            step();
        end
        reset = 1'b0;
        ext_reset_n = 1'b1;
        steps(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
